// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine copying one CPU memory page into the PPU OAM-data register
// Ports: I_clock/I_reset clock and synchronous active-high reset; I_cycle_en end-of-CPU-cycle pulse;
//   I_cpu_addr/I_cpu_wren/I_cpu_data CPU write bus that triggers a transfer;
//   O_cpu_rdy/O_busy CPU stall and transfer status; O_mem_addr/O_mem_rden/I_mem_data DMA read port;
//   O_ppu_addr/O_ppu_wren/O_ppu_data PPU host register write port.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAM_DATA_REG = 3'd4,
  parameter int          XFER_LEN     = 256
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_cycle_en,
  input  logic [15:0] I_cpu_addr,
  input  logic        I_cpu_wren,
  input  logic [7:0]  I_cpu_data,
  output logic        O_cpu_rdy,
  output logic        O_busy,
  output logic [15:0] O_mem_addr,
  output logic        O_mem_rden,
  input  logic [7:0]  I_mem_data,
  output logic [2:0]  O_ppu_addr,
  output logic        O_ppu_wren,
  output logic [7:0]  O_ppu_data
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, GET, PUT} state_t;
  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
  state_t     r_state;
  logic       r_parity;
  logic [7:0] r_cnt;
  logic [7:0] r_page;
  logic [7:0] r_data;
  logic       w_get;
  logic       w_put;
  always_ff @(posedge I_clock)
    if (I_reset) begin
      r_state  <= IDLE;
      r_parity <= 1'b0;
      r_cnt    <= '0;
      r_page   <= '0;
      r_data   <= '0;
    end else if (I_cycle_en) begin
      r_parity <= ~r_parity;
      case (r_state)
        IDLE:
          if (I_cpu_wren && I_cpu_addr == DMA_REG_ADDR) begin
            r_state <= HALT;
            r_page  <= I_cpu_data;
            r_cnt   <= '0;
          end
        // parity here already reflects the toggle taken at the trigger edge
        HALT:  r_state <= r_parity ? ALIGN : GET;
        ALIGN: r_state <= GET;
        GET: begin
          r_data  <= I_mem_data;
          r_state <= PUT;
        end
        PUT: begin
          r_cnt   <= r_cnt + 8'd1;
          r_state <= (r_cnt == LAST) ? IDLE : GET;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign w_get      = r_state == GET;
  assign w_put      = r_state == PUT;
  assign O_cpu_rdy  = r_state == IDLE;
  assign O_busy     = ~O_cpu_rdy;
  assign O_mem_rden = w_get;
  assign O_mem_addr = w_get ? {r_page, r_cnt} : '0;
  // strobe only on the cycle-end clock so the PPU sees one write per byte; reset suppresses it
  assign O_ppu_wren = w_put & I_cycle_en & ~I_reset;
  assign O_ppu_addr = w_put ? OAM_DATA_REG : '0;
  assign O_ppu_data = w_put ? r_data : '0;
endmodule
